risc16_loader: RTL and testbench
================================

RISC16_LOADER -- requirements
Module: risc16_loader

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 16'h0000: byte address where the first image word is written.
REQ-002 SHALL have parameter MAX_WORDS, default 16'd4096: largest accepted word count.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_data  input  8  image byte stream.
REQ-006 SHALL have port s_valid  input  1  s_data valid.
REQ-007 SHALL have port s_ready  output  1  loader accepts byte; a transfer occurs when s_valid & s_ready are high at a rising edge.
REQ-008 SHALL have port restart  input  1  synchronous request to reload the image.
REQ-009 SHALL have port mem_addr  output  16  memory byte address, always even.
REQ-010 SHALL have port mem_dout  output  16  write data, {high byte, low byte}.
REQ-011 SHALL have port mem_we0  output  1  upper-byte-lane write strobe.
REQ-012 SHALL have port mem_we1  output  1  lower-byte-lane write strobe.
REQ-013 SHALL have port core_rst  output  1  active-high reset to the processor core.
REQ-014 SHALL have port done  output  1  image loaded, core running.
REQ-015 SHALL have port err  output  1  load failed.

Function
REQ-016 SHALL accept the image format: word count N (2 bytes, high first), then 2N data bytes (high byte first per word), then the optional checksum (REQ-030).
REQ-017 SHALL implement states LEN_HI, LEN_LO, DAT_HI, DAT_LO, CSUM_HI, CSUM_LO, DRAIN, RUN, ERR; each byte state advances on one transfer.
REQ-018 SHALL drive s_ready=1 in LEN_HI through CSUM_LO and s_ready=0 in DRAIN, RUN and ERR.
REQ-019 SHALL go LEN_LO -> ERR when N > MAX_WORDS, and LEN_LO -> the state after the data phase when N=0.
REQ-020 SHALL pulse mem_we0 and mem_we1 together for exactly one cycle, starting the cycle after each DAT_LO transfer, with mem_addr = ADDR_BASE + 2*k for word k (0-based) and 16-bit wraparound.
REQ-021 SHALL hold mem_we0=mem_we1=0 at all other times; mem_addr and mem_dout are don't-care when the strobes are low.
REQ-022 SHALL enter DRAIN on the final image transfer and enter RUN one cycle later, so core_rst falls on the second rising edge after the final transfer, after the last write is committed.
REQ-023 SHALL drive core_rst=1 in every state except RUN; done=1 only in RUN; err=1 only in ERR; all three SHALL be registered outputs.
REQ-024 SHALL, when restart=1 at a rising edge in any state, go to LEN_HI and clear the word counter and checksum.
REQ-025 SHALL discard any byte transferred in the same cycle as restart and any partial word.
REQ-026 SHALL suppress a write strobe already scheduled for the edge at which restart is sampled.
REQ-027 SHALL hold ERR until restart or rst.

Reset
REQ-028 SHALL on rst=0, asynchronously, set state=LEN_HI, core_rst=1, done=0, err=0, mem_we0=mem_we1=0, and clear the counter and checksum.
REQ-029 SHALL, when rst deasserts, accept the first byte at the first following rising edge with s_valid=1.

Configuration
REQ-030 SHALL, with LOADER_CSUM_EN defined, accumulate the 16-bit modulo-2^16 sum of data words, read a 2-byte checksum (high first) after the data, and enter DRAIN on a match or ERR on a mismatch.
REQ-031 SHALL, without LOADER_CSUM_EN, omit CSUM_HI and CSUM_LO and enter DRAIN directly after the last data byte, or after LEN_LO when N=0.

Verification
REQ-032 SHALL cover: bytes 00 02 12 34 AB CD (+ checksum BE 01 if enabled) -> writes 0x1234@0x0000 and 0xABCD@0x0002; core_rst falls 2 edges after the last byte; done=1.
REQ-033 SHALL cover: s_valid toggled 1/0 every cycle over the same image -> identical writes; no write issued for cycles with s_valid=0.
REQ-034 SHALL cover: MAX_WORDS=4, length bytes 00 05 -> err=1, s_ready=0, no write strobes, core_rst stays 1.
REQ-035 SHALL cover (LOADER_CSUM_EN): image 00 01 00 10 with checksum 00 11 -> err=1, core_rst=1; with checksum 00 10 -> done=1.
REQ-036 SHALL cover: restart pulsed after byte 3 of an image -> no write for the partial word; a following complete image loads from 0x0000.
REQ-037 SHALL cover: rst=0 asserted mid-DAT_LO, asynchronous to clk -> core_rst=1 and strobes low immediately, with state LEN_HI after release.

Source files
------------

// File: rtl/risc16_loader.sv
// Boot loader: streams a length-prefixed 16-bit image into memory, then releases the core.
// Optional trailing checksum verification is enabled by defining LOADER_CSUM_EN.
module risc16_loader #(
  parameter logic [15:0] ADDR_BASE = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        restart,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_dout,
  output logic        mem_we0,
  output logic        mem_we1,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    StLenHi, StLenLo, StDatHi, StDatLo, StCsumHi, StCsumLo, StDrain, StRun, StErr
  } state_e;

`ifdef LOADER_CSUM_EN
  localparam state_e StPostData = StCsumHi;
`else
  localparam state_e StPostData = StDrain;
`endif

  state_e      state_q;
  logic [7:0]  hi_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] dout_q;
  logic        core_rst_q;
  logic        done_q;
  logic        err_q;
`ifdef LOADER_CSUM_EN
  logic [15:0] csum_q;
`endif

  logic        xfer;
  logic [15:0] word;

  assign xfer = s_valid & s_ready;
  assign word = {hi_q, s_data};

  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      StLenHi, StLenLo, StDatHi, StDatLo, StCsumHi, StCsumLo: s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StLenHi;
      hi_q       <= 8'h00;
      len_q      <= 16'h0000;
      cnt_q      <= 16'h0000;
      we_q       <= 1'b0;
      addr_q     <= 16'h0000;
      dout_q     <= 16'h0000;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum_q     <= 16'h0000;
`endif
    end else if (restart) begin
      // Same-cycle byte is dropped and any pending strobe is cancelled.
      state_q    <= StLenHi;
      cnt_q      <= 16'h0000;
      we_q       <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum_q     <= 16'h0000;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        StLenHi: begin
          if (xfer) begin
            hi_q    <= s_data;
            state_q <= StLenLo;
          end
        end
        StLenLo: begin
          if (xfer) begin
            len_q <= word;
            cnt_q <= 16'h0000;
            if (word > MAX_WORDS) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else if (word == 16'h0000) begin
              state_q <= StPostData;
            end else begin
              state_q <= StDatHi;
            end
          end
        end
        StDatHi: begin
          if (xfer) begin
            hi_q    <= s_data;
            state_q <= StDatLo;
          end
        end
        StDatLo: begin
          if (xfer) begin
            we_q   <= 1'b1;
            addr_q <= ADDR_BASE + {cnt_q[14:0], 1'b0};
            dout_q <= word;
            cnt_q  <= cnt_q + 16'd1;
`ifdef LOADER_CSUM_EN
            csum_q <= csum_q + word;
`endif
            state_q <= (cnt_q + 16'd1 == len_q) ? StPostData : StDatHi;
          end
        end
`ifdef LOADER_CSUM_EN
        StCsumHi: begin
          if (xfer) begin
            hi_q    <= s_data;
            state_q <= StCsumLo;
          end
        end
        StCsumLo: begin
          if (xfer) begin
            if (word == csum_q) begin
              state_q <= StDrain;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        StDrain: begin
          // Last write commits at this edge, so the core is released now.
          state_q    <= StRun;
          core_rst_q <= 1'b0;
          done_q     <= 1'b1;
        end
        StRun, StErr: state_q <= state_q;
        default: state_q <= StLenHi;
      endcase
    end
  end

  assign mem_addr = addr_q;
  assign mem_dout = dout_q;
  assign mem_we0  = we_q;
  assign mem_we1  = we_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_risc16_loader.sv
// Directed bench for risc16_loader (MAX_WORDS=4); checksum bytes are added when LOADER_CSUM_EN is set.
module tb_risc16_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        restart = 1'b0;
  logic [15:0] mem_addr, mem_dout;
  logic        mem_we0, mem_we1;
  logic        core_rst, done, err;

  int errors = 0;
  int checks = 0;
  int skew = 0;
  logic [15:0] wa[$];
  logic [15:0] wd[$];
  logic [7:0]  img[$];

  risc16_loader #(
    .ADDR_BASE(16'h0000),
    .MAX_WORDS(16'd4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .restart (restart),
    .mem_addr(mem_addr),
    .mem_dout(mem_dout),
    .mem_we0 (mem_we0),
    .mem_we1 (mem_we1),
    .core_rst(core_rst),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Log every strobed write at the falling edge.
  always @(negedge clk) begin
    if (mem_we0 !== mem_we1) skew++;
    if (mem_we0 === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_dout);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    t = 0;
    while (s_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("send_timeout", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_img(input int gap);
    foreach (img[i]) begin
      send(img[i]);
      for (int g = 0; g < gap; g++) @(negedge clk);
    end
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_nwr"}, wa.size(), 2);
    check({tag, "_a0"}, (wa.size() > 0) ? wa[0] : 16'hDEAD, 16'h0000);
    check({tag, "_d0"}, (wd.size() > 0) ? wd[0] : 16'hDEAD, 16'h1234);
    check({tag, "_a1"}, (wa.size() > 1) ? wa[1] : 16'hDEAD, 16'h0002);
    check({tag, "_d1"}, (wd.size() > 1) ? wd[1] : 16'hDEAD, 16'hABCD);
  endtask

  task automatic set_img_a();
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CSUM_EN
    img.push_back(8'hBE);
    img.push_back(8'h01);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #1 rst = 1'b0;
    #1;
    check("rst_core_rst", core_rst, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_we", {mem_we0, mem_we1}, 0);
    check("rst_ready", s_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back image; release two edges after the final byte
    set_img_a();
    send_img(0);
    check("a_drain_core_rst", core_rst, 1);
    check("a_drain_ready", s_ready, 0);
    @(posedge clk);
    #1;
    check("a_core_rst", core_rst, 0);
    check("a_done", done, 1);
    check_two_writes("a");

    // s_valid toggling 1/0
    pulse_restart();
    check("rs_core_rst", core_rst, 1);
    check("rs_done", done, 0);
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_img(1);
    send(8'hCD);
    check("t_we", mem_we0, 1);
    check("t_addr", mem_addr, 16'h0002);
    check("t_dout", mem_dout, 16'hABCD);
    @(posedge clk);
    #1;
    check("t_we_pulse", mem_we0, 0);
`ifdef LOADER_CSUM_EN
    send(8'hBE);
    @(negedge clk);
    send(8'h01);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("t_done", done, 1);
    check_two_writes("t");

    // Length above MAX_WORDS
    pulse_restart();
    img = '{8'h00, 8'h05};
    send_img(0);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_err", err, 1);
    check("ovf_ready", s_ready, 0);
    check("ovf_core_rst", core_rst, 1);
    check("ovf_done", done, 0);
    check("ovf_nwr", wa.size(), 0);

    // Restart after byte 3, then a full image
    pulse_restart();
    check("rs_err_clear", err, 0);
    img = '{8'h00, 8'h02, 8'h12};
    send_img(0);
    pulse_restart();
    set_img_a();
    send_img(0);
    @(posedge clk);
    #1;
    check("p_done", done, 1);
    check_two_writes("p");

    // Restart coincident with a DAT_LO transfer cancels that write
    pulse_restart();
    img = '{8'h00, 8'h02, 8'h12};
    send_img(0);
    @(negedge clk);
    s_data  = 8'h34;
    s_valid = 1'b1;
    restart = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    restart = 1'b0;
    check("c_we", mem_we0, 0);
    check("c_ready", s_ready, 1);
    @(posedge clk);
    #1;
    check("c_nwr", wa.size(), 0);

    // Zero-length image
    pulse_restart();
`ifdef LOADER_CSUM_EN
    img = '{8'h00, 8'h00, 8'h00, 8'h00};
`else
    img = '{8'h00, 8'h00};
`endif
    send_img(0);
    check("z_core_rst", core_rst, 1);
    @(posedge clk);
    #1;
    check("z_done", done, 1);
    check("z_nwr", wa.size(), 0);

`ifdef LOADER_CSUM_EN
    // Checksum mismatch and match
    pulse_restart();
    img = '{8'h00, 8'h01, 8'h00, 8'h10, 8'h00, 8'h11};
    send_img(0);
    repeat (2) @(posedge clk);
    #1;
    check("cs_bad_err", err, 1);
    check("cs_bad_core_rst", core_rst, 1);
    pulse_restart();
    img = '{8'h00, 8'h01, 8'h00, 8'h10, 8'h00, 8'h10};
    send_img(0);
    repeat (2) @(posedge clk);
    #1;
    check("cs_ok_done", done, 1);
    check("cs_ok_err", err, 0);
`endif

    // Async reset while a strobe is high
    pulse_restart();
    img = '{8'h00, 8'h02, 8'h12, 8'h34};
    send_img(0);
    check("ar_we_before", mem_we0, 1);
    #2 rst = 1'b0;
    #1;
    check("ar_we_now", {mem_we0, mem_we1}, 0);
    check("ar_core_rst", core_rst, 1);
    @(negedge clk);
    rst = 1'b1;

    // Async reset mid-DAT_LO, then a clean load
    wa.delete();
    wd.delete();
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_img(0);
    @(negedge clk);
    s_data  = 8'hCD;
    s_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("ar2_we", {mem_we0, mem_we1}, 0);
    check("ar2_core_rst", core_rst, 1);
    check("ar2_done", done, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wa.delete();
    wd.delete();
    check("ar2_ready", s_ready, 1);
    set_img_a();
    send_img(0);
    @(posedge clk);
    #1;
    check("ar2_done_after", done, 1);
    check_two_writes("ar2");

    check("strobe_skew", skew, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
